dma_src_reader: RTL

Upstream stage of the DMA datapath. Accepts a descriptor (source address, burst length), issues one AXI4 INCR read burst to source memory, and pushes every returned data beat into the read-data FIFO that the destination write stage drains. It checks response codes and burst framing and reports done or error to the dispatcher/CSR logic.

---
 rtl/dma_src_reader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dma_src_reader.sv
// dma_src_reader: issues one AXI4 INCR read burst per descriptor and
// streams returned beats into the read-data FIFO, flagging resp/framing errors.
//
// Ports:
//   clk, reset (async, active-high)
//   go, src_addr, length          descriptor in (sampled only when idle)
//   reset_dispatcher              clears the ERROR state
//   rd_fsm_done, rd_fsm_error     completion status to the dispatcher/CSR
//   resp_err, last_err            sticky per-burst error flags
//   beat_count                    beats accepted in the current/last burst
//   busy                          block is not idle
//   ar*/r*                        AXI4 read address and read data channels
//   fifo_wr_en, fifo_wr_data, fifo_full   read-data FIFO write side
module dma_src_reader #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              reset_dispatcher,
    output logic              rd_fsm_done,
    output logic              rd_fsm_error,
    output logic              resp_err,
    output logic              last_err,
    output logic [LEN_W:0]    beat_count,
    output logic              busy,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [LEN_W-1:0]  arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic              fifo_full
);

    localparam logic [2:0] ARSIZE_C = 3'($clog2(DATA_W / 8));

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_ADDR = 5'b00010,
        S_DATA = 5'b00100,
        S_DONE = 5'b01000,
        S_ERR  = 5'b10000
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept;
    logic idx_last;
    logic early_last;
    logic miss_last;
    logic beat_err;
    logic burst_end;

    assign rready     = (state == S_DATA) && !fifo_full;
    assign accept     = rvalid && rready;
    assign idx_last   = (beat_count == {1'b0, arlen});
    assign early_last = rlast && !idx_last;
    assign miss_last  = !rlast && idx_last;
    assign beat_err   = rresp[1] | early_last | miss_last;
    // The burst stops on rlast or on the beat arlen promised, whichever first.
    assign burst_end  = accept && (rlast || idx_last);

    // The offending beat itself is dropped along with everything after it.
    assign fifo_wr_en   = accept && !resp_err && !last_err && !beat_err;
    assign fifo_wr_data = rdata;

    assign arvalid      = (state == S_ADDR);
    assign arsize       = ARSIZE_C;
    assign arburst      = 2'b01;
    assign rd_fsm_done  = (state == S_DONE);
    assign rd_fsm_error = (state == S_ERR);
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            araddr     <= '0;
            arlen      <= '0;
            beat_count <= '0;
            resp_err   <= 1'b0;
            last_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && go) begin
                araddr     <= src_addr;
                arlen      <= length;
                beat_count <= '0;
                resp_err   <= 1'b0;
                last_err   <= 1'b0;
            end
            if (accept) begin
                beat_count <= beat_count + 1'b1;
                if (rresp[1]) begin
                    resp_err <= 1'b1;
                end
                if (early_last || miss_last) begin
                    last_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (arready) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (burst_end) begin
                    if (resp_err || last_err || beat_err) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (reset_dispatcher) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
